gripper_sequencer: RTL

GRIPPER_SEQUENCER -- requirements
Module: gripper_sequencer

---
 rtl/gripper_sequencer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/gripper_sequencer.sv
// Soft-gripper grasp sequencer: inflate, settle in band, hold, vent.
// Supervises the pump block and PID loop with a timeout fault path.
module gripper_sequencer #(
  parameter logic signed [15:0] SP_MAX        = 16'sd1000,
  parameter logic        [15:0] TOL           = 16'd20,
  parameter int unsigned        SETTLE_TICKS  = 200,
  parameter int unsigned        TIMEOUT_TICKS = 5000,
  parameter int unsigned        VENT_TICKS    = 1000
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               tick,
  input  logic               grasp_req,
  input  logic               release_req,
  input  logic               abort,
  input  logic               fault_clr,
  input  logic signed [15:0] setpoint,
  input  logic signed [15:0] pressure,
  output logic               pump_start,
  output logic               pid_enable,
  output logic signed [15:0] pid_setpoint,
  output logic               busy,
  output logic               holding,
  output logic               fault,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INFLATE = 3'd1,
    S_SETTLE  = 3'd2,
    S_HOLD    = 3'd3,
    S_VENT    = 3'd4,
    S_FAULT   = 3'd5
  } state_t;

  state_t             r_state;
  logic [31:0]        r_settle;
  logic [31:0]        r_to;
  logic [31:0]        r_vent;
  logic signed [15:0] r_sp;
  logic               r_pump;
  logic               r_pid;
  logic               r_busy;
  logic               r_hold;
  logic               r_fault;

  state_t             w_nxt;
  logic [31:0]        w_settle_nxt;
  logic [31:0]        w_to_nxt;
  logic [31:0]        w_vent_nxt;
  logic signed [15:0] w_sp_nxt;
  logic signed [15:0] w_sp_clamp;
  logic signed [16:0] w_err;
  logic [16:0]        w_abs;
  logic               w_inband;
  logic [31:0]        w_to_inc;
  logic [31:0]        w_settle_inc;
  logic [31:0]        w_vent_inc;
  logic               w_stop;

  always_comb begin
    w_sp_clamp = setpoint;
    if (setpoint < 16'sd0)
      w_sp_clamp = 16'sd0;
    else if (setpoint > SP_MAX)
      w_sp_clamp = SP_MAX;
  end

  // Widen by one bit so the error never overflows.
  assign w_err    = {pressure[15], pressure} - {r_sp[15], r_sp};
  assign w_abs    = w_err[16] ? (~w_err + 17'd1) : w_err;
  assign w_inband = (w_abs <= {1'b0, TOL});
  assign w_stop   = abort | release_req;

  assign w_to_inc     = (r_to >= TIMEOUT_TICKS) ? r_to : r_to + 32'd1;
  assign w_settle_inc = (r_settle >= SETTLE_TICKS) ?
                        r_settle : r_settle + 32'd1;
  assign w_vent_inc   = (r_vent >= VENT_TICKS) ? r_vent : r_vent + 32'd1;

  always_comb begin
    w_nxt        = r_state;
    w_settle_nxt = r_settle;
    w_to_nxt     = r_to;
    w_vent_nxt   = r_vent;
    w_sp_nxt     = r_sp;
    case (r_state)
      S_IDLE: if (grasp_req) begin
        w_nxt        = S_INFLATE;
        w_sp_nxt     = w_sp_clamp;
        w_to_nxt     = '0;
        w_settle_nxt = '0;
      end
      S_INFLATE, S_SETTLE: begin
        if (w_stop) begin
          w_nxt      = S_VENT;
          w_vent_nxt = '0;
        end else if (tick) begin
          w_to_nxt = w_to_inc;
          if (w_to_inc >= TIMEOUT_TICKS) begin
            w_nxt = S_FAULT;
          end else if (!w_inband) begin
            w_nxt        = S_INFLATE;
            w_settle_nxt = '0;
          end else if (r_state == S_INFLATE) begin
            w_nxt        = S_SETTLE;
            w_settle_nxt = '0;
          end else begin
            w_settle_nxt = w_settle_inc;
            if (w_settle_inc >= SETTLE_TICKS)
              w_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: if (w_stop) begin
        w_nxt      = S_VENT;
        w_vent_nxt = '0;
      end
      S_VENT: if (tick) begin
        w_vent_nxt = w_vent_inc;
        if (w_vent_inc >= VENT_TICKS)
          w_nxt = S_IDLE;
      end
      S_FAULT: if (fault_clr) begin
        w_nxt      = S_VENT;
        w_vent_nxt = '0;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state  <= S_IDLE;
      r_settle <= '0;
      r_to     <= '0;
      r_vent   <= '0;
      r_sp     <= '0;
      r_pump   <= 1'b0;
      r_pid    <= 1'b0;
      r_busy   <= 1'b0;
      r_hold   <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_state  <= w_nxt;
      r_settle <= w_settle_nxt;
      r_to     <= w_to_nxt;
      r_vent   <= w_vent_nxt;
      r_sp     <= w_sp_nxt;
      r_pump   <= (w_nxt == S_INFLATE) || (w_nxt == S_SETTLE) ||
                  (w_nxt == S_HOLD);
      r_pid    <= (w_nxt == S_INFLATE) || (w_nxt == S_SETTLE) ||
                  (w_nxt == S_HOLD);
      r_busy   <= (w_nxt != S_IDLE);
      r_hold   <= (w_nxt == S_HOLD);
      r_fault  <= (w_nxt == S_FAULT);
    end
  end

  assign pump_start   = r_pump;
  assign pid_enable   = r_pid;
  assign pid_setpoint = r_sp;
  assign busy         = r_busy;
  assign holding      = r_hold;
  assign fault        = r_fault;
  assign state        = r_state;

endmodule
